// File: rtl/fp_accum_ctrl.sv
// Sequencing/accumulation stage around a combinational FP32 add/sub unit.
// Streams operands into a running accumulator and pulses done on completion.
module fp_accum_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_start,
    input  logic [CNT_W-1:0] in_len,
    input  logic             in_sub,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             out_ready,
    output logic [31:0]      out_addA,
    output logic [31:0]      out_addB,
    output logic             out_addsub,
    input  logic [31:0]      in_addRes,
    output logic [31:0]      out_result,
    output logic             out_done,
    output logic             out_busy,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      acc;
    logic [31:0]      x_q;
    logic             xv_q;
    logic             first;
    logic             sub_q;
    logic [CNT_W-1:0] remain;
    logic [CNT_W-1:0] count;
    logic             xfer;
    logic             start_ok;

    assign xfer     = in_valid && (state == RUN);
    assign start_ok = in_start && (state == IDLE);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_ready = 1'b0;
        out_done  = 1'b0;
        out_busy  = 1'b1;
        unique case (state)
            IDLE: begin
                out_busy = 1'b0;
                if (in_start) begin
                    state_nxt = (in_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                out_ready = 1'b1;
                if (xfer && (remain == CNT_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The adder cannot take a zero operand, so the first element bypasses it.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            acc    <= '0;
            x_q    <= '0;
            xv_q   <= 1'b0;
            first  <= 1'b0;
            sub_q  <= 1'b0;
            remain <= '0;
            count  <= '0;
        end else if (start_ok) begin
            acc   <= '0;
            count <= '0;
            if (in_len != '0) begin
                remain <= in_len;
                sub_q  <= in_sub;
                first  <= 1'b1;
            end
        end else begin
            if (xv_q) begin
                if (first) begin
                    acc   <= sub_q ? {~x_q[31], x_q[30:0]} : x_q;
                    first <= 1'b0;
                end else begin
                    acc <= in_addRes;
                end
            end
            xv_q <= xfer;
            if (xfer) begin
                x_q    <= in_data;
                remain <= remain - CNT_W'(1);
                count  <= count + CNT_W'(1);
            end
        end
    end

    assign out_addA   = acc;
    assign out_addB   = x_q;
    assign out_addsub = sub_q;
    assign out_result = acc;
    assign out_count  = count;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Bench for fp_accum_ctrl: ideal FP32 adder model, vector table,
// hand sequences and randomized reductions against a real-valued sum.
module tb_fp_accum_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             sub = 1'b0;
    logic             valid = 1'b0;
    logic [31:0]      data = '0;
    logic             ready;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic             addsub;
    logic [31:0]      add_res;
    logic [31:0]      result;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;
    logic [31:0] stim [32];

    fp_accum_ctrl #(.CNT_W(CNT_W)) dut (
        .in_clk     (clk),
        .in_rst_n   (rst_n),
        .in_start   (start),
        .in_len     (len),
        .in_sub     (sub),
        .in_valid   (valid),
        .in_data    (data),
        .out_ready  (ready),
        .out_addA   (add_a),
        .out_addB   (add_b),
        .out_addsub (addsub),
        .in_addRes  (add_res),
        .out_result (result),
        .out_done   (done),
        .out_busy   (busy),
        .out_count  (count)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        logic [30:0] v;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        v = {e[7:0], d[51:29]};
        if (d[28:0] > 29'h1000_0000 || (d[28:0] == 29'h1000_0000 && v[0]))
            v = v + 31'd1;
        return {d[63], v};
    endfunction

    function automatic logic [31:0] fp_addsub(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic s);
        return r2f(f2r(a) + (s ? -f2r(b) : f2r(b)));
    endfunction

    always_comb add_res = fp_addsub(add_a, add_b, addsub);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run(input int n, input bit s, input bit rnd,
                       input logic [7:0] vpat, input bit poke,
                       input logic [31:0] exp_res, input int exp_lat,
                       input string tag);
        int cyc;
        int idx;
        int p;
        int bub;
        int lat_ref;
        bit v;
        bit got;
        len   = CNT_W'(n);
        sub   = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; idx = 0; p = 0; bub = 0; got = 0;
        while (cyc <= 300) begin
            check({tag, "_ready"}, 32'(ready), 32'(idx < n));
            check({tag, "_count"}, 32'(count), 32'(idx));
            if (done) begin
                got = 1;
                break;
            end
            if (poke && cyc == 2) begin
                start = 1'b1;
                len   = CNT_W'(9);
                sub   = ~s;
            end else begin
                start = 1'b0;
            end
            if (rnd) v = ($urandom_range(0, 9) < 7);
            else     v = (p < 8) ? vpat[p] : 1'b1;
            valid = v;
            data  = stim[idx % 32];
            if (idx < n) begin
                if (v) idx++;
                else   bub++;
            end
            p++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        valid = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        lat_ref = (n == 0) ? 1 : n + 2 + bub;
        check({tag, "_latency"}, 32'(cyc), 32'(lat_ref));
        if (exp_lat >= 0) check({tag, "_latency_tbl"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_result_hold"}, result, exp_res);
    endtask

    typedef struct {
        int               len;
        bit               sub;
        logic [3:0][31:0] d;
        logic [7:0]       vpat;
        bit               poke;
        logic [31:0]      exp_res;
        int               exp_lat;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int n;
        bit s;
        int mag;
        int val;
        real sum;
        int hi;

        tbl[0] = '{len: 3, sub: 0,
                   d: {32'h0, 32'h40400000, 32'h40000000, 32'h3F800000},
                   vpat: 8'hFF, poke: 0, exp_res: 32'h40C00000, exp_lat: 5};
        tbl[1] = '{len: 2, sub: 1,
                   d: {32'h0, 32'h0, 32'h40000000, 32'h40A00000},
                   vpat: 8'hFF, poke: 0, exp_res: 32'hC0E00000, exp_lat: 4};
        tbl[2] = '{len: 0, sub: 0, d: '0,
                   vpat: 8'hFF, poke: 0, exp_res: 32'h0, exp_lat: 1};
        tbl[3] = '{len: 4, sub: 0,
                   d: {4{32'h3F800000}},
                   vpat: 8'hD9, poke: 0, exp_res: 32'h40800000, exp_lat: 9};
        tbl[4] = '{len: 3, sub: 0,
                   d: {32'h0, 32'h40400000, 32'h40000000, 32'h3F800000},
                   vpat: 8'hFF, poke: 1, exp_res: 32'h40C00000, exp_lat: 5};

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_add_b", add_b, 32'd0);
        check("rst_addsub", 32'(addsub), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) stim[j] = tbl[i].d[j];
            run(tbl[i].len, tbl[i].sub, 1'b0, tbl[i].vpat, tbl[i].poke,
                tbl[i].exp_res, tbl[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Negated first element, then the adder sees A=-5, B=2, subtract.
        len = 2; sub = 1; start = 1;
        @(posedge clk); #1;
        start = 0; valid = 1; data = 32'h40A00000;
        @(posedge clk); #1;
        data = 32'h40000000;
        @(posedge clk); #1;
        valid = 0;
        check("sub_add_a", add_a, 32'hC0A00000);
        check("sub_add_b", add_b, 32'h40000000);
        check("sub_addsub", 32'(addsub), 32'd1);
        check("sub_add_res", add_res, 32'hC0E00000);
        check("sub_ready_drain", 32'(ready), 32'd0);
        @(posedge clk); #1;
        check("sub_done", 32'(done), 32'd1);
        check("sub_result", result, 32'hC0E00000);
        @(posedge clk); #1;

        // Reset in the middle of a reduction.
        len = 5; sub = 0; start = 1;
        @(posedge clk); #1;
        start = 0; valid = 1; data = 32'h3F800000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_add_b", add_b, 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        valid = 0;
        hi = 0;
        repeat (8) begin
            @(posedge clk); #1;
            hi += int'(done) + int'(busy);
        end
        check("post_rst_quiet", 32'(hi), 32'd0);

        for (int r = 0; r < 20; r++) begin
            n   = $urandom_range(1, 16);
            s   = 1'($urandom_range(0, 1));
            sum = 0.0;
            for (int i = 0; i < n; i++) begin
                mag = $urandom_range(1, 1000);
                val = $urandom_range(0, 1) ? -mag : mag;
                stim[i] = r2f(real'(val));
                sum = sum + (s ? -real'(val) : real'(val));
            end
            run(n, s, 1'b1, 8'hFF, 1'b0, r2f(sum), -1,
                $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_accum_ctrl.md
# fp_accum_ctrl

Sequencing and accumulation stage wrapped around the combinational FP32 add/subtract unit. It accepts a stream of IEEE-754 single-precision operands over a valid/ready handshake and drives the adder's A/B/control inputs. It registers the adder's result back into a running accumulator and reports the final sum with a one-cycle done pulse. It provides one-element-per-cycle reductions (sums, running differences) for the FP unit without exposing the adder's combinational path to upstream logic.

## Interface
- CNT_W, 8, width of the element-count field and counter

- in_clk  input  1  clock, all state updates on rising edge
- in_rst_n  input  1  asynchronous active-low reset
- in_start  input  1  start a reduction; sampled only in IDLE
- in_len  input  CNT_W  number of elements; sampled with in_start
- in_sub  input  1  0: acc = x0 + x1 + ...; 1: acc = -x0 - x1 - ...; sampled with in_start
- in_valid  input  1  upstream operand valid
- in_data  input  32  FP32 operand
- out_ready  output  1  block accepts in_data this cycle
- out_addA  output  32  adder operand A (accumulator)
- out_addB  output  32  adder operand B (staged operand)
- out_addsub  output  1  adder control (0 add, 1 subtract B)
- in_addRes  input  32  adder result
- out_result  output  32  accumulator value, held after completion
- out_done  output  1  one-cycle pulse, out_result final
- out_busy  output  1  high in any state except IDLE
- out_count  output  CNT_W  elements accepted in current reduction

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_start=1 with in_len≠0 latches len into remain, in_sub into sub_q, clears acc to 0x00000000, clears out_count, sets first=1, and goes to RUN. in_start=1 with in_len=0 clears acc and goes to DONE.
- RUN: out_ready=1. A transfer is in_valid & out_ready. Each transfer:
  - x_q <= in_data; xv_q <= 1
  - remain decrements; out_count increments
  - the transfer that brings remain to 0 moves the FSM to DRAIN
- No transfer in a RUN cycle: xv_q <= 0.
- Accumulate, every cycle with xv_q=1:
  - first=1: acc <= sub_q ? {~x_q[31], x_q[30:0]} : x_q, and first <= 0. The adder is bypassed because it cannot represent a zero operand.
  - first=0: acc <= in_addRes.
- Adder drive, continuous: out_addA=acc, out_addB=x_q, out_addsub=sub_q.
- DRAIN: out_ready=0. The last staged operand is accumulated, xv_q <= 0, FSM goes to DONE.
- DONE: out_done=1 for exactly one cycle, then IDLE. out_result=acc and holds until the next accepted in_start.
- in_start outside IDLE is ignored. in_len and in_sub changes outside IDLE have no effect.
- No rounding or special-value handling is added; the result is whatever the adder returns.

## Timing
- Reset values:
  - outputs: out_ready=0, out_done=0, out_busy=0, out_count=0, out_result=0, out_addA=0, out_addB=0, out_addsub=0
  - state: IDLE; acc, x_q, xv_q, first, remain, sub_q all cleared
- Start at edge k: RUN and out_ready=1 from cycle k+1.
- Throughput: one operand per cycle with in_valid held high.
- Last transfer at edge t: DRAIN in cycle t+1, acc final at edge t+1, out_done=1 in cycle t+2, IDLE at t+3.
- For in_len=N with no bubbles: done arrives N+2 cycles after the start edge.
- in_len=0 at edge k: out_done=1 in cycle k+1, out_result=0x00000000.
- Bubbles (in_valid=0) stall without side effects; acc holds.
- out_count wraps only if in_len=2^CNT_W-1 plus extra transfers, which cannot occur because out_ready drops after the last element.
- Reset asserted mid-RUN or mid-DRAIN returns to reset values on the next evaluation, independent of clock. No done pulse is emitted.

## Test plan
- Bench setup: in_addRes is driven from an ideal FP32 add/sub model of out_addA/out_addB/out_addsub.
- len=3, sub=0, data 0x3F800000, 0x40000000, 0x40400000 back-to-back -> out_done 5 cycles after start edge; out_result=0x40C00000 (6.0); out_count=3.
- len=2, sub=1, data 0x40A00000, 0x40000000 -> first accumulate gives acc=0xC0A00000; adder sees A=0xC0A00000, B=0x40000000, addsub=1; out_result=0xC0E00000 (-7.0).
- len=0 -> out_done in the cycle after start; out_result=0x00000000; out_ready never asserted.
- len=4, data 0x3F800000 each, in_valid pattern 1,0,0,1,1,0,1 -> out_count steps only on transfers; out_result=0x40800000; out_ready=0 after the 4th transfer.
- in_start pulsed again during RUN with len=9 -> ignored, original reduction completes. Then in_rst_n low during a new RUN -> all outputs 0 and out_busy=0 immediately; no out_done pulse afterwards.
